// File: rtl/harvard_data_ram.sv
// harvard_data_ram: wait-stated word data memory with byte enables and a sticky protocol-error flag
module harvard_data_ram #(
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] data_address,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [31:0] data_writedata,
   input  logic [3:0]  data_byteenable,
   output logic        data_waitrequest,
   output logic [31:0] data_readdata,
   output logic        protocol_error
);
   typedef enum logic {IDLE, WAIT} state_t;
   localparam bit ZERO_WAIT = LATENCY == 0;
   localparam logic [3:0] CNT_INIT = ZERO_WAIT ? 4'd0 : 4'(LATENCY - 1);
   logic [31:0] mem [2**ADDR_WIDTH];
   state_t state;
   logic [3:0] cnt;
   logic [ADDR_WIDTH-1:0] lat_idx, idx, wr_idx;
   logic lat_wr, req, done, commit, unused_addr;
   logic [31:0] lat_data, wr_data;
   logic [3:0] lat_be, wr_be;
   assign unused_addr = ^{data_address[31:ADDR_WIDTH+2], data_address[1:0]};
   assign req = data_read | data_write;
   assign idx = data_address[ADDR_WIDTH+1:2];
   // completion needs the request still held; a dropped request in WAIT is an abort
   assign done = state == WAIT && cnt == 4'd0 && req;
   always_comb begin
      data_waitrequest = state == WAIT ? cnt != 4'd0 : req && !ZERO_WAIT;
      data_readdata = ZERO_WAIT && state == IDLE && data_read && !data_write ? mem[idx] :
                      done && !lat_wr ? mem[lat_idx] : '0;
      commit = rst_n && (state == IDLE ? ZERO_WAIT && data_write : done && lat_wr);
      wr_idx = state == IDLE ? idx : lat_idx;
      wr_data = state == IDLE ? data_writedata : lat_data;
      wr_be = state == IDLE ? data_byteenable : lat_be;
   end
   always_ff @(posedge clk)
      if (commit)
         for (int i = 0; i < 4; i++)
            if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         protocol_error <= 1'b0;
         lat_idx <= '0;
         lat_wr <= 1'b0;
         lat_data <= '0;
         lat_be <= '0;
      end else begin
         if ((state == IDLE && data_read && data_write) || (state == WAIT && !req))
            protocol_error <= 1'b1;
         if (state == IDLE) begin
            if (req && !ZERO_WAIT) begin
               state <= WAIT;
               cnt <= CNT_INIT;
               lat_idx <= idx;
               lat_wr <= data_write;
               lat_data <= data_writedata;
               lat_be <= data_byteenable;
            end
         end else if (!req || cnt == 4'd0)
            state <= IDLE;
         else
            cnt <= cnt - 4'd1;
      end
endmodule

// File: doc/harvard_data_ram.md
# harvard_data_ram

Word-organised data memory that answers the CPU's data-side read/write strobes on the Harvard core's data port. Requests are stretched with a `data_waitrequest` handshake and a programmable fixed latency, and stores honour per-byte write enables. A sticky error flag captures protocol violations. The block sits opposite the CPU control/datapath on the data bus and replaces the zero-wait behavioural memory in testbenches.

## Interface
- `ADDR_WIDTH`, default 8: word-index width; memory depth is 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, default 2: number of wait cycles per transaction, legal range 0..15.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `data_address` input, 32 bits: byte address. Bits [1:0] are ignored. Word index is [ADDR_WIDTH+1:2]. Higher bits are ignored, so addresses alias.
- `data_read` input, 1 bit: read request.
- `data_write` input, 1 bit: write request.
- `data_writedata` input, 32 bits: store data.
- `data_byteenable` input, 4 bits: bit i enables byte lane i (bits [8i+7:8i]) on a write. Ignored on reads.
- `data_waitrequest` output, 1 bit: high while the request must be held.
- `data_readdata` output, 32 bits: read word. Valid only in the completion cycle of a read, otherwise 0.
- `protocol_error` output, 1 bit: sticky error flag.

## Operation
- Request = `data_read | data_write`. If both are high, the request is treated as a write. Read data is 0 in that case and `protocol_error` is set at the edge.
- States:
  - IDLE: no transaction in flight.
  - WAIT: transaction latched, with a 4-bit down-counter `cnt`.
- IDLE, no request: `data_waitrequest`=0, `data_readdata`=0.
- IDLE, request, LATENCY=0: zero-wait completion.
  - `data_waitrequest`=0 combinationally.
  - Read: `data_readdata` = mem[index] combinationally.
  - Write: enabled lanes commit at this edge.
  - State stays IDLE.
- IDLE, request, LATENCY>0:
  - `data_waitrequest`=1.
  - Address index, op, write data and byte enables are latched at the edge.
  - `cnt` <= LATENCY-1; state -> WAIT.
- WAIT, cnt≠0: `data_waitrequest`=1; `cnt` decrements.
- WAIT, cnt=0: completion cycle.
  - `data_waitrequest`=0.
  - Read: `data_readdata` = mem[latched index].
  - Write: latched enabled lanes commit at the edge.
  - State -> IDLE.
- Latched values are used in WAIT. Changes to address or data after acceptance have no effect.
- Abort: if the request drops during WAIT, the state goes to IDLE at the next edge. No write commits, and `protocol_error` is set.
- A request still high in the cycle after completion is a new transaction. This holds even if the address is unchanged.
- `protocol_error` is cleared only by reset.
- Memory contents are not reset and are undefined until written. Bench preload via hierarchical access is permitted.

## Timing
- Reset (async, while `rst_n`=0):
  - state=IDLE, `cnt`=0, `protocol_error`=0.
  - Any pending write is dropped; memory is untouched.
  - Outputs follow IDLE rules.
- Reset released mid-request: the request is seen as new in IDLE on the first edge after release.
- A transaction issued in cycle 0 with LATENCY=L:
  - `data_waitrequest`=1 in cycles 0..L-1.
  - `data_waitrequest`=0 in cycle L (the completion cycle).
  - Write data is visible to a read accepted in cycle L+1 or later.
- Throughput: one transaction per L+1 cycles. Back-to-back transactions need no idle cycle.
- Read-after-write to the same word, LATENCY=0, consecutive cycles: the read returns the new data.
- `data_readdata` and `data_waitrequest` are combinational from state, `cnt`, the request inputs and the array. No other outputs are combinational from inputs.

## Test plan
- Reset, then idle with LATENCY=2 → `data_waitrequest`=0, `data_readdata`=0, `protocol_error`=0.
- Write 0xDEADBEEF to 0x10 with byteenable 4'b1111 (waitrequest high for 2 cycles), then read 0x10 → waitrequest 1,1,0; readdata 0xDEADBEEF in the completion cycle only, 0 otherwise.
- Partial write: write 0x11223344 to 0x10 with byteenable 4'b0101, after the previous scenario → read 0x10 returns 0xDE22BE44.
- Aliasing: ADDR_WIDTH=8, write 0xCAFEF00D to 0x404, read 0x004 → readdata 0xCAFEF00D.
- Abort: start a write of 0x12345678 to 0x20, drop `data_write` after 1 wait cycle → no commit (0x20 retains its prior value), `protocol_error`=1 until `rst_n` is pulsed low.
- LATENCY=0 rebuild: write 0xA5A5A5A5 to 0x8, read 0x8 on the next cycle → `data_waitrequest` never asserted, readdata 0xA5A5A5A5. Both strobes high → write performed, readdata 0, `protocol_error`=1.
